// File: rtl/det5_sequencer.sv
// det5_sequencer: 5x5 signed determinant by row-0 Laplace expansion over one time-shared det4 unit.
// Latency: done 11 cycles after start with minor_ack tied high; +1 per ack wait cycle. Optional DET5_SATURATE_EN clamps det.
// Backpressure: minor_req holds each minor stable until minor_ack; start is ignored while busy or in DONE.
module det5_sequencer #(
  parameter int ACC_W       = 32,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [199:0] matrix,
  output logic         busy,
  output logic         done,
  output logic [7:0]   det,
  output logic         ovf,
  output logic [127:0] minor,
  output logic         minor_req,
  input  logic         minor_ack,
  input  logic [7:0]   minor_det,
  input  logic         minor_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_MAC, S_DONE} state_t;

  localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] NEG_LIM = ACC_W'(-128);

  state_t                    state_q, state_d;
  logic [199:0]              mat_q;
  logic [2:0]                j_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic                      sticky_q;
  logic signed [7:0]         mdet_q;
  logic [TW-1:0]             tcnt_q;
  logic [7:0]                det_q;
  logic                      ovf_q;

  logic                      timeout_hit;
  logic signed [7:0]         elem0;
  logic signed [15:0]        prod;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   acc_next;
  logic [7:0]                det_calc;
  logic                      ovf_calc;
  logic [127:0]              minor_c;

  assign timeout_hit = (ACK_TIMEOUT > 0) && (tcnt_q == TW'(ACK_TIMEOUT));

  // Row-0 element selected by the current column.
  always_comb begin
    elem0 = '0;
    for (int c = 0; c < 5; c++) begin
      if (j_q == 3'(c)) elem0 = mat_q[199-8*c -: 8];
    end
  end

  // 8x8 signed product is exact in 16 bits, then sign-extended for accumulation.
  assign prod     = $signed({{8{elem0[7]}}, elem0}) * $signed({{8{mdet_q[7]}}, mdet_q});
  assign term     = {{(ACC_W-16){prod[15]}}, prod};
  assign acc_next = j_q[0] ? (acc_q - term) : (acc_q + term);
  assign ovf_calc = sticky_q | (acc_next > POS_LIM) | (acc_next < NEG_LIM);

  always_comb begin
`ifdef DET5_SATURATE_EN
    if (acc_next > POS_LIM)      det_calc = 8'h7F;
    else if (acc_next < NEG_LIM) det_calc = 8'h80;
    else                         det_calc = acc_next[7:0];
`else
    det_calc = acc_next[7:0];
`endif
  end

  // Minor for column j: rows 1..4 with column j skipped.
  always_comb begin
    minor_c = '0;
    for (int jj = 0; jj < 5; jj++) begin
      if (j_q == 3'(jj)) begin
        for (int r = 0; r < 4; r++) begin
          for (int k = 0; k < 4; k++) begin
            minor_c[127-8*(4*r+k) -: 8] = mat_q[199-8*(5*(r+1)+((k < jj) ? k : k+1)) -: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ: begin
        if (minor_ack)        state_d = S_MAC;
        else if (timeout_hit) state_d = S_DONE;
      end
      S_MAC:  state_d = (j_q == 3'd4) ? S_DONE : S_REQ;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_REQ) || (state_q == S_MAC);
    done      = (state_q == S_DONE);
    minor_req = (state_q == S_REQ);
    minor     = (state_q == S_REQ) ? minor_c : '0;
    det       = det_q;
    ovf       = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mat_q    <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      mdet_q   <= '0;
      tcnt_q   <= '0;
      det_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (state_q != S_REQ) tcnt_q <= '0;
      else if ((ACK_TIMEOUT > 0) && !minor_ack && !timeout_hit) tcnt_q <= tcnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            mat_q    <= matrix;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            j_q      <= '0;
          end
        end
        S_REQ: begin
          if (minor_ack) begin
            mdet_q   <= minor_det;
            sticky_q <= sticky_q | minor_ovf;
          end else if (timeout_hit) begin
            sticky_q <= 1'b1;
            det_q    <= '0;
            ovf_q    <= 1'b1;
          end
        end
        S_MAC: begin
          acc_q <= acc_next;
          if (j_q == 3'd4) begin
            det_q <= det_calc;
            ovf_q <= ovf_calc;
          end else begin
            j_q <= j_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_det5_sequencer.sv
// Bench for det5_sequencer: det4 responder with programmable ack delay, Leibniz-sum reference model, scoreboard on done.
module tb_det5_sequencer;

  localparam int ACK_TO = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [199:0] matrix;
  logic         busy, done, ovf, minor_req, minor_ack, minor_ovf;
  logic [7:0]   det, minor_det;
  logic [127:0] minor;

  always #5 clk = ~clk;

  det5_sequencer #(.ACC_W(32), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .matrix(matrix),
    .busy(busy), .done(done), .det(det), .ovf(ovf),
    .minor(minor), .minor_req(minor_req), .minor_ack(minor_ack),
    .minor_det(minor_det), .minor_ovf(minor_ovf)
  );

  typedef longint mat_t [5][5];
  typedef struct { longint det; bit ovf; int cyc; } exp_t;

  exp_t   sb_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  int     ack_delay = 0;
  bit     ack_en   = 1'b1;
  int     force_idx = -1;
  int     req_age  = 0;
  int     ack_count = 0;
  int     busy_ref = -1000;
  bit     prev_req = 1'b0;
  logic [127:0] prev_minor = '0;
  mat_t   resp_m;
  longint resp_d;

  // Determinant as the signed sum over all permutations (n <= 5).
  function automatic longint det_n(input mat_t m, input int n);
    longint sum, prod;
    int p[5];
    int tot, t, inv;
    bit ok;
    sum = 0;
    tot = 1;
    for (int k = 0; k < n; k++) tot = tot * n;
    for (int idx = 0; idx < tot; idx++) begin
      t = idx; ok = 1'b1; inv = 0; prod = 1;
      for (int k = 0; k < n; k++) begin p[k] = t % n; t = t / n; end
      for (int a = 0; a < n; a++)
        for (int b = a + 1; b < n; b++) begin
          if (p[a] == p[b]) ok = 1'b0;
          else if (p[a] > p[b]) inv++;
        end
      if (ok) begin
        for (int k = 0; k < n; k++) prod = prod * m[k][p[k]];
        sum = (inv % 2 == 1) ? sum - prod : sum + prod;
      end
    end
    return sum;
  endfunction

  function automatic longint wrap8(input longint x);
    logic [7:0] b;
    b = x[7:0];
    return longint'($signed(b));
  endfunction

  function automatic void model(input mat_t a, input int fidx, output longint edet, output bit eovf);
    mat_t s;
    longint md, acc;
    bit o;
    acc = 0; o = 1'b0;
    for (int j = 0; j < 5; j++) begin
      for (int r = 0; r < 5; r++) for (int k = 0; k < 5; k++) s[r][k] = 0;
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) s[r][k] = a[r+1][(k < j) ? k : k + 1];
      md = det_n(s, 4);
      if (md > 127 || md < -128 || fidx == j) o = 1'b1;
      acc = acc + ((j % 2 == 1) ? -1 : 1) * a[0][j] * wrap8(md);
    end
    eovf = o || acc > 127 || acc < -128;
`ifdef DET5_SATURATE_EN
    edet = (acc > 127) ? 127 : (acc < -128) ? -128 : wrap8(acc);
`else
    edet = wrap8(acc);
`endif
  endfunction

  function automatic logic [199:0] pack(input mat_t a);
    logic [199:0] v;
    v = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) v[199-8*(5*r+c) -: 8] = a[r][c][7:0];
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // det4 responder: acks after ack_delay cycles of minor_req.
  always @(posedge clk) begin
    if (minor_req && !minor_ack) req_age <= req_age + 1;
    else                         req_age <= 0;
    if (!busy)          ack_count <= 0;
    else if (minor_ack) ack_count <= ack_count + 1;
  end

  assign minor_ack = ack_en && minor_req && (req_age == ack_delay);

  always_comb begin
    for (int r = 0; r < 5; r++) for (int k = 0; k < 5; k++) resp_m[r][k] = 0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) resp_m[r][k] = longint'($signed(minor[127-8*(4*r+k) -: 8]));
    resp_d    = det_n(resp_m, 4);
    minor_det = resp_d[7:0];
    minor_ovf = (resp_d > 127) || (resp_d < -128) || (force_idx == ack_count);
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: done=1 with no job outstanding (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("det", longint'($signed(det)), e.det);
        check("ovf", longint'(ovf), longint'(e.ovf));
        check("done_cycle", longint'(cyc), longint'(e.cyc));
      end
    end
    if (minor_req && prev_req) begin
      n_checks++;
      if (minor !== prev_minor) begin
        n_fail++;
        $display("FAIL minor_stable: got %h, expected %h", minor, prev_minor);
      end
    end
    if (busy_ref >= 0 && cyc - busy_ref <= 12)
      check("busy_window", longint'(busy), longint'(cyc - busy_ref >= 1 && cyc - busy_ref <= 10));
    prev_req   = minor_req;
    prev_minor = minor;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input mat_t a, input int d, input bit en, input int fidx,
                         input bit mid_start, input bit chk_busy);
    longint ed;
    bit eo;
    exp_t e;
    ack_delay = d; ack_en = en; force_idx = fidx;
    model(a, fidx, ed, eo);
    if (!en) begin ed = 0; eo = 1'b1; end
    e.det = ed; e.ovf = eo;
    e.cyc = cyc + (en ? 1 + 5 * (d + 2) : ACK_TO + 2);
    sb_q.push_back(e);
    if (chk_busy) busy_ref = cyc;
    matrix = pack(a);
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 25; b++) matrix[199-8*b -: 8] = 8'($urandom);
    for (int k = 0; k < 200 && sb_q.size() != 0; k++) begin
      start = (mid_start && k == 4);
      tick();
    end
    start = 1'b0;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL job_timeout: %0d results outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
    busy_ref = -1000;
    tick();
  endtask

  function automatic mat_t diag(input longint v);
    mat_t m;
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) m[r][c] = (r == c) ? v : 0;
    return m;
  endfunction

  initial begin
    mat_t a;
    rst = 1'b1; start = 1'b0; matrix = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_det", longint'(det), 0);
    check("rst_ovf", longint'(ovf), 0);
    check("rst_minor_req", longint'(minor_req), 0);
    check("rst_minor_zero", longint'(minor != '0), 0);
    tick();
    rst = 1'b0;
    tick();

    run_job(diag(1), 0, 1'b1, -1, 1'b0, 1'b1);
    run_job(diag(2), 0, 1'b1, -1, 1'b0, 1'b0);
    a = diag(1); a[3] = a[1];
    run_job(a, 0, 1'b1, -1, 1'b0, 1'b0);
    a = diag(1); a[0][0] = 0; a[0][1] = 1; a[1][0] = 1; a[1][1] = 0;
    run_job(a, 0, 1'b1, -1, 1'b0, 1'b0);
    run_job(diag(3), 0, 1'b1, -1, 1'b0, 1'b0);
    run_job(diag(1), 3, 1'b1, -1, 1'b1, 1'b0);
    run_job(diag(1), 0, 1'b0, -1, 1'b0, 1'b0);
    run_job(diag(1), 0, 1'b1, 2, 1'b0, 1'b0);

    // Reset in cycle 6 of a job: no done, outputs cleared.
    ack_delay = 0; ack_en = 1'b1; force_idx = -1;
    matrix = pack(diag(2));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("abort_busy", longint'(busy), 0);
    check("abort_minor_req", longint'(minor_req), 0);
    check("abort_det", longint'(det), 0);
    check("abort_ovf", longint'(ovf), 0);
    check("abort_done", longint'(done), 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    run_job(diag(1), 0, 1'b1, -1, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          a[r][c] = (n % 3 == 0) ? longint'($urandom_range(0, 255)) - 128
                                 : longint'($urandom_range(0, 6)) - 3;
      run_job(a, int'($urandom_range(0, 3)), 1'b1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
